// File: rtl/vga_timing_if.sv
// Raster timing bundle between the timing generator and the pixel pipeline.
// Widths must match the generator's derived HW/VW.
interface vga_timing_if #(
  parameter int HW = 11,
  parameter int VW = 10
) ();
  logic          en;
  logic [HW-1:0] hc;
  logic [VW-1:0] vc;
  logic          visible;
  logic          hsync;
  logic          vsync;
  logic          line_start;
  logic          frame_start;
  logic          visible_d;
  logic          hsync_d;
  logic          vsync_d;

  modport master (
    input  en,
    output hc, vc, visible, hsync, vsync, line_start, frame_start,
           visible_d, hsync_d, vsync_d
  );

  modport slave (
    output en,
    input  hc, vc, visible, hsync, vsync, line_start, frame_start,
           visible_d, hsync_d, vsync_d
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: h/v counters, sync/visible decode, line/frame strobes,
// and a DELAY-deep copy of visible/hsync/vsync to stay aligned with the pixel pipeline.
module vga_timing_gen #(
  parameter int H_VISIBLE = 1024,
  parameter int H_FP      = 24,
  parameter int H_SYNC    = 136,
  parameter int H_BP      = 160,
  parameter int V_VISIBLE = 768,
  parameter int V_FP      = 3,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 29,
  parameter bit SYNC_POL  = 1'b0,
  parameter int DELAY     = 1
) (
  input logic          clk,
  input logic          rst,
  vga_timing_if.master bus
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam int HS_BEG_I = H_VISIBLE + H_FP;
  localparam int HS_END_I = H_VISIBLE + H_FP + H_SYNC;
  localparam int VS_BEG_I = V_VISIBLE + V_FP;
  localparam int VS_END_I = V_VISIBLE + V_FP + V_SYNC;
  localparam int H_LAST_I = H_TOTAL - 1;
  localparam int V_LAST_I = V_TOTAL - 1;

  // Decode constants carry one extra bit so a region end equal to 2**HW still compares correctly.
  localparam logic [HW:0]   H_VIS_C = H_VISIBLE[HW:0];
  localparam logic [HW:0]   HS_BEG  = HS_BEG_I[HW:0];
  localparam logic [HW:0]   HS_END  = HS_END_I[HW:0];
  localparam logic [VW:0]   V_VIS_C = V_VISIBLE[VW:0];
  localparam logic [VW:0]   VS_BEG  = VS_BEG_I[VW:0];
  localparam logic [VW:0]   VS_END  = VS_END_I[VW:0];
  localparam logic [HW-1:0] H_LAST  = H_LAST_I[HW-1:0];
  localparam logic [VW-1:0] V_LAST  = V_LAST_I[VW-1:0];
  localparam logic [2:0]    IDLE    = {1'b0, ~SYNC_POL, ~SYNC_POL};

  logic [HW-1:0] hc_q, hc_d;
  logic [VW-1:0] vc_q, vc_d;
  logic          ls_q, ls_d;
  logic          fs_q, fs_d;

  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    ls_d = 1'b0;
    fs_d = 1'b0;
    if (bus.en) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        ls_d = 1'b1;
        if (vc_q == V_LAST) begin
          vc_d = '0;
          fs_d = 1'b1;
        end else begin
          vc_d = vc_q + 1'b1;
        end
      end else begin
        hc_d = hc_q + 1'b1;
      end
    end
  end

  // A reset-forced return to 0 deliberately produces no strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      hc_q <= '0;
      vc_q <= '0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
    end
  end

  logic [HW:0] hc_x;
  logic [VW:0] vc_x;
  logic        vis, hs, vs;
  logic [2:0]  cur, tap;

  assign hc_x = {1'b0, hc_q};
  assign vc_x = {1'b0, vc_q};
  assign vis  = (hc_x < H_VIS_C) && (vc_x < V_VIS_C);
  assign hs   = ((hc_x >= HS_BEG) && (hc_x < HS_END)) ? SYNC_POL : ~SYNC_POL;
  assign vs   = ((vc_x >= VS_BEG) && (vc_x < VS_END)) ? SYNC_POL : ~SYNC_POL;
  assign cur  = {vis, hs, vs};

  generate
    if (DELAY == 0) begin : g_nodly
      assign tap = cur;
    end else begin : g_dly
      logic [DELAY-1:0][2:0] dly_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DELAY; i++) dly_q[i] <= IDLE;
        end else begin
          dly_q[0] <= cur;
          for (int i = 1; i < DELAY; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign tap = dly_q[DELAY-1];
    end
  endgenerate

  assign bus.hc          = hc_q;
  assign bus.vc          = vc_q;
  assign bus.visible     = vis;
  assign bus.hsync       = hs;
  assign bus.vsync       = vs;
  assign bus.line_start  = ls_q;
  assign bus.frame_start = fs_q;
  assign bus.visible_d   = tap[2];
  assign bus.hsync_d     = tap[1];
  assign bus.vsync_d     = tap[0];
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: small 16x8 raster (DELAY 2 and DELAY 0 copies) plus the default 1344x806 raster.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_s, rst_b;
  always #5 clk = ~clk;

  vga_timing_if #(.HW(4),  .VW(3))  sif ();
  vga_timing_if #(.HW(4),  .VW(3))  zif ();
  vga_timing_if #(.HW(11), .VW(10)) bif ();
  assign zif.en = sif.en;

  vga_timing_gen #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
                   .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
                   .SYNC_POL(1'b0), .DELAY(2))
    u_small (.clk(clk), .rst(rst_s), .bus(sif));

  vga_timing_gen #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
                   .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
                   .SYNC_POL(1'b0), .DELAY(0))
    u_zero (.clk(clk), .rst(rst_s), .bus(zif));

  vga_timing_gen u_big (.clk(clk), .rst(rst_b), .bus(bif));

  localparam logic [2:0] IDLE = 3'b011;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int exp_hc, exp_vc;
  logic els, efs;
  logic [2:0] h1, h2;

  function automatic logic f_vis(int hc, int vc);
    return (hc < 8) && (vc < 4);
  endfunction
  function automatic logic f_hs(int hc);
    return !(hc == 10 || hc == 11);
  endfunction
  function automatic logic f_vs(int vc);
    return vc != 5;
  endfunction

  // Advance one clock on the small raster and update the reference state.
  task automatic step(input logic en_v, input logic rst_v);
    sif.en = en_v;
    rst_s  = rst_v;
    h2 = h1;
    h1 = {f_vis(exp_hc, exp_vc), f_hs(exp_hc), f_vs(exp_vc)};
    @(posedge clk);
    @(negedge clk);
    cyc++;
    els = 1'b0;
    efs = 1'b0;
    if (rst_v) begin
      exp_hc = 0; exp_vc = 0; h1 = IDLE; h2 = IDLE;
    end else if (en_v) begin
      if (exp_hc == 15) begin
        exp_hc = 0;
        els = 1'b1;
        if (exp_vc == 7) begin exp_vc = 0; efs = 1'b1; end
        else exp_vc++;
      end else begin
        exp_hc++;
      end
    end
  endtask

  task automatic test_reset;
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    checks += 9;
    if (sif.hc !== 4'd0)        begin errors++; $display("FAIL reset_hc got=%0d exp=0", sif.hc); end
    if (sif.vc !== 3'd0)        begin errors++; $display("FAIL reset_vc got=%0d exp=0", sif.vc); end
    if (sif.line_start !== 1'b0)  begin errors++; $display("FAIL reset_ls got=%b exp=0", sif.line_start); end
    if (sif.frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got=%b exp=0", sif.frame_start); end
    if (sif.visible_d !== 1'b0) begin errors++; $display("FAIL reset_vis_d got=%b exp=0", sif.visible_d); end
    if (sif.hsync_d !== 1'b1)   begin errors++; $display("FAIL reset_hs_d got=%b exp=1", sif.hsync_d); end
    if (sif.vsync_d !== 1'b1)   begin errors++; $display("FAIL reset_vs_d got=%b exp=1", sif.vsync_d); end
    if (sif.visible !== 1'b1)   begin errors++; $display("FAIL reset_vis got=%b exp=1", sif.visible); end
    if (sif.hsync !== 1'b1)     begin errors++; $display("FAIL reset_hs got=%b exp=1", sif.hsync); end
  endtask

  task automatic test_frame;
    int last_ls = -1, last_fs = -1, nfs = 0;
    for (int i = 0; i < 260; i++) begin
      step(1'b1, 1'b0);
      checks += 7;
      if (sif.hc !== exp_hc[3:0]) begin errors++; $display("FAIL frame_hc cyc=%0d got=%0d exp=%0d", cyc, sif.hc, exp_hc); end
      if (sif.vc !== exp_vc[2:0]) begin errors++; $display("FAIL frame_vc cyc=%0d got=%0d exp=%0d", cyc, sif.vc, exp_vc); end
      if (sif.visible !== f_vis(exp_hc, exp_vc)) begin errors++; $display("FAIL frame_vis cyc=%0d got=%b", cyc, sif.visible); end
      if (sif.hsync !== f_hs(exp_hc)) begin errors++; $display("FAIL frame_hs cyc=%0d got=%b", cyc, sif.hsync); end
      if (sif.vsync !== f_vs(exp_vc)) begin errors++; $display("FAIL frame_vs cyc=%0d got=%b", cyc, sif.vsync); end
      if (sif.line_start !== els) begin errors++; $display("FAIL frame_ls cyc=%0d got=%b exp=%b", cyc, sif.line_start, els); end
      if (sif.frame_start !== efs) begin errors++; $display("FAIL frame_fs cyc=%0d got=%b exp=%b", cyc, sif.frame_start, efs); end
      if (sif.line_start === 1'b1) begin
        if (last_ls >= 0) begin
          checks++;
          if (cyc - last_ls != 16) begin errors++; $display("FAIL ls_period got=%0d exp=16", cyc - last_ls); end
        end
        last_ls = cyc;
      end
      if (sif.frame_start === 1'b1) begin
        nfs++;
        checks++;
        if (sif.hc !== 4'd0 || sif.vc !== 3'd0) begin errors++; $display("FAIL fs_origin hc=%0d vc=%0d exp=0/0", sif.hc, sif.vc); end
        if (last_fs >= 0) begin
          checks++;
          if (cyc - last_fs != 128) begin errors++; $display("FAIL fs_period got=%0d exp=128", cyc - last_fs); end
        end
        last_fs = cyc;
      end
    end
    checks++;
    if (nfs != 2) begin errors++; $display("FAIL fs_count got=%0d exp=2", nfs); end
  endtask

  task automatic test_delay;
    for (int i = 0; i < 48; i++) begin
      step(1'b1, 1'b0);
      checks += 3;
      if (sif.visible_d !== h2[2]) begin errors++; $display("FAIL dly_vis cyc=%0d got=%b exp=%b", cyc, sif.visible_d, h2[2]); end
      if (sif.hsync_d !== h2[1])   begin errors++; $display("FAIL dly_hs cyc=%0d got=%b exp=%b", cyc, sif.hsync_d, h2[1]); end
      if (sif.vsync_d !== h2[0])   begin errors++; $display("FAIL dly_vs cyc=%0d got=%b exp=%b", cyc, sif.vsync_d, h2[0]); end
    end
  endtask

  task automatic test_delay0;
    for (int i = 0; i < 130; i++) begin
      step(1'b1, 1'b0);
      checks += 4;
      if (zif.hc !== exp_hc[3:0]) begin errors++; $display("FAIL d0_hc cyc=%0d got=%0d exp=%0d", cyc, zif.hc, exp_hc); end
      if (zif.visible_d !== f_vis(exp_hc, exp_vc)) begin errors++; $display("FAIL d0_vis cyc=%0d got=%b", cyc, zif.visible_d); end
      if (zif.hsync_d !== f_hs(exp_hc)) begin errors++; $display("FAIL d0_hs cyc=%0d got=%b", cyc, zif.hsync_d); end
      if (zif.vsync_d !== f_vs(exp_vc)) begin errors++; $display("FAIL d0_vs cyc=%0d got=%b", cyc, zif.vsync_d); end
    end
  endtask

  task automatic test_en_toggle;
    int last_fs = -1, nper = 0;
    for (int i = 0; i < 600; i++) begin
      step((i % 2) == 0, 1'b0);
      checks += 4;
      if (sif.hc !== exp_hc[3:0]) begin errors++; $display("FAIL en_hc cyc=%0d got=%0d exp=%0d", cyc, sif.hc, exp_hc); end
      if (sif.vc !== exp_vc[2:0]) begin errors++; $display("FAIL en_vc cyc=%0d got=%0d exp=%0d", cyc, sif.vc, exp_vc); end
      if (sif.line_start !== els) begin errors++; $display("FAIL en_ls cyc=%0d got=%b exp=%b", cyc, sif.line_start, els); end
      if (sif.frame_start !== efs) begin errors++; $display("FAIL en_fs cyc=%0d got=%b exp=%b", cyc, sif.frame_start, efs); end
      if (sif.frame_start === 1'b1) begin
        if (last_fs >= 0) begin
          nper++;
          checks++;
          if (cyc - last_fs != 256) begin errors++; $display("FAIL en_fs_period got=%0d exp=256", cyc - last_fs); end
        end
        last_fs = cyc;
      end
    end
    checks++;
    if (nper < 1) begin errors++; $display("FAIL en_fs_seen got=%0d exp>=1", nper); end
  endtask

  task automatic test_mid_reset;
    int n = 0;
    while (!(exp_hc == 5 && exp_vc == 3) && n < 300) begin
      step(1'b1, 1'b0);
      n++;
    end
    checks++;
    if (sif.hc !== 4'd5 || sif.vc !== 3'd3) begin
      errors++; $display("FAIL mid_reach hc=%0d vc=%0d exp=5/3", sif.hc, sif.vc);
    end
    step(1'b1, 1'b1);
    checks += 7;
    if (sif.hc !== 4'd0) begin errors++; $display("FAIL mid_hc got=%0d exp=0", sif.hc); end
    if (sif.vc !== 3'd0) begin errors++; $display("FAIL mid_vc got=%0d exp=0", sif.vc); end
    if (sif.frame_start !== 1'b0) begin errors++; $display("FAIL mid_fs got=%b exp=0", sif.frame_start); end
    if (sif.line_start !== 1'b0)  begin errors++; $display("FAIL mid_ls got=%b exp=0", sif.line_start); end
    if (sif.visible_d !== 1'b0) begin errors++; $display("FAIL mid_vis_d got=%b exp=0", sif.visible_d); end
    if (sif.hsync_d !== 1'b1)   begin errors++; $display("FAIL mid_hs_d got=%b exp=1", sif.hsync_d); end
    if (sif.vsync_d !== 1'b1)   begin errors++; $display("FAIL mid_vs_d got=%b exp=1", sif.vsync_d); end
    step(1'b1, 1'b0);
    checks += 3;
    if (sif.hc !== 4'd1) begin errors++; $display("FAIL mid_resume_hc got=%0d exp=1", sif.hc); end
    if (sif.frame_start !== 1'b0) begin errors++; $display("FAIL mid_resume_fs got=%b exp=0", sif.frame_start); end
    if (sif.visible_d !== 1'b0) begin errors++; $display("FAIL mid_resume_vis_d got=%b exp=0", sif.visible_d); end
  endtask

  task automatic test_default;
    sif.en = 1'b0;
    rst_b  = 1'b1;
    bif.en = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    checks += 4;
    if (bif.hc !== 11'd0)     begin errors++; $display("FAIL big_rst_hc got=%0d exp=0", bif.hc); end
    if (bif.hsync !== 1'b1)   begin errors++; $display("FAIL big_rst_hs got=%b exp=1", bif.hsync); end
    if (bif.vsync !== 1'b1)   begin errors++; $display("FAIL big_rst_vs got=%b exp=1", bif.vsync); end
    if (bif.hsync_d !== 1'b1) begin errors++; $display("FAIL big_rst_hs_d got=%b exp=1", bif.hsync_d); end
    rst_b = 1'b0;
    for (int n = 1; n <= 1345; n++) begin
      @(posedge clk); @(negedge clk);
      case (n)
        1023: begin checks++; if (bif.visible !== 1'b1) begin errors++; $display("FAIL big_vis1023 got=%b exp=1", bif.visible); end end
        1024: begin checks++; if (bif.visible !== 1'b0) begin errors++; $display("FAIL big_vis1024 got=%b exp=0", bif.visible); end end
        1047: begin checks++; if (bif.hsync !== 1'b1) begin errors++; $display("FAIL big_hs1047 got=%b exp=1", bif.hsync); end end
        1048: begin checks++; if (bif.hsync !== 1'b0) begin errors++; $display("FAIL big_hs1048 got=%b exp=0", bif.hsync); end end
        1049: begin checks++; if (bif.hsync_d !== 1'b0) begin errors++; $display("FAIL big_hsd1049 got=%b exp=0", bif.hsync_d); end end
        1183: begin checks++; if (bif.hsync !== 1'b0) begin errors++; $display("FAIL big_hs1183 got=%b exp=0", bif.hsync); end end
        1184: begin checks++; if (bif.hsync !== 1'b1) begin errors++; $display("FAIL big_hs1184 got=%b exp=1", bif.hsync); end end
        1185: begin checks++; if (bif.hsync_d !== 1'b1) begin errors++; $display("FAIL big_hsd1185 got=%b exp=1", bif.hsync_d); end end
        1343: begin
          checks += 3;
          if (bif.hc !== 11'd1343) begin errors++; $display("FAIL big_hc1343 got=%0d exp=1343", bif.hc); end
          if (bif.vc !== 10'd0)    begin errors++; $display("FAIL big_vc1343 got=%0d exp=0", bif.vc); end
          if (bif.line_start !== 1'b0) begin errors++; $display("FAIL big_ls1343 got=%b exp=0", bif.line_start); end
        end
        1344: begin
          checks += 6;
          if (bif.hc !== 11'd0) begin errors++; $display("FAIL big_hc_wrap got=%0d exp=0", bif.hc); end
          if (bif.vc !== 10'd1) begin errors++; $display("FAIL big_vc_wrap got=%0d exp=1", bif.vc); end
          if (bif.line_start !== 1'b1)  begin errors++; $display("FAIL big_ls_wrap got=%b exp=1", bif.line_start); end
          if (bif.frame_start !== 1'b0) begin errors++; $display("FAIL big_fs_wrap got=%b exp=0", bif.frame_start); end
          if (bif.visible !== 1'b1) begin errors++; $display("FAIL big_vis_wrap got=%b exp=1", bif.visible); end
          if (bif.vsync !== 1'b1)   begin errors++; $display("FAIL big_vs_wrap got=%b exp=1", bif.vsync); end
        end
        1345: begin checks++; if (bif.line_start !== 1'b0) begin errors++; $display("FAIL big_ls_width got=%b exp=0", bif.line_start); end end
        default: ;
      endcase
    end
  endtask

  initial begin
    rst_s = 1'b1; rst_b = 1'b1;
    sif.en = 1'b0; bif.en = 1'b0;
    exp_hc = 0; exp_vc = 0; els = 1'b0; efs = 1'b0;
    h1 = IDLE; h2 = IDLE;
    @(negedge clk);
    test_reset;
    test_frame;
    test_delay;
    test_delay0;
    test_en_toggle;
    test_mid_reset;
    test_default;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
